hex_dump_engine: RTL

Parametrised memory-to-text dumper. On a start pulse it reads a programmable address range from a synchronous RAM port and emits an ASCII hex listing, one character at a time, to a byte-wide UART transmitter. The block sits between a BRAM read port and serial_tx. It replaces fixed-format debug dumpers with configurable address width, word width, line length, read latency, wrap-around ranges and abort.

---
 rtl/hex_dump_engine.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/hex_dump_engine.sv
// Streams an ASCII hex listing of a RAM address range to a byte-wide transmitter.
// Line format: "$" + address digits + "#" + space-separated words + CR LF.
module hex_dump_engine #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 16,
    parameter int RD_LAT         = 1
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int AD  = (ADDR_W + 3) / 4;
    localparam int AW4 = 4 * AD;
    localparam int ND  = DATA_W / 4;
    localparam int SW  = (AW4 > DATA_W) ? AW4 : DATA_W;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_HDR   = 4'd1;
    localparam logic [3:0] S_ADDR  = 4'd2;
    localparam logic [3:0] S_SEP   = 4'd3;
    localparam logic [3:0] S_FETCH = 4'd4;
    localparam logic [3:0] S_WAIT  = 4'd5;
    localparam logic [3:0] S_DIGIT = 4'd6;
    localparam logic [3:0] S_SPACE = 4'd7;
    localparam logic [3:0] S_CR    = 4'd8;
    localparam logic [3:0] S_LF    = 4'd9;
    localparam logic [3:0] S_FIN   = 4'd10;

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]   left_q, left_d;
    logic [7:0]        line_q, line_d;
    logic [5:0]        nib_q, nib_d;
    logic [2:0]        wait_q, wait_d;
    logic [SW-1:0]     sh_q, sh_d;
    logic              abort_q, abort_d;

    logic              busy_w;
    logic              accept;
    logic              abort_now;
    logic [ADDR_W-1:0] span;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign busy_w    = (state_q != S_IDLE) && (state_q != S_FIN);
    assign tx_valid  = (state_q == S_HDR)   || (state_q == S_ADDR)  || (state_q == S_SEP) ||
                       (state_q == S_DIGIT) || (state_q == S_SPACE) || (state_q == S_CR)  ||
                       (state_q == S_LF);
    assign accept    = tx_valid & tx_ready;
    // A same-cycle abort counts as if it had already been latched.
    assign abort_now = abort_q | (abort & busy_w);
    assign span      = end_addr - start_addr;

    assign busy     = busy_w;
    assign done     = (state_q == S_FIN);
    assign mem_rd   = (state_q == S_FETCH);
    assign mem_addr = mem_addr_q;

    always_comb begin
        case (state_q)
            S_HDR:           tx_data = 8'h24;
            S_SEP:           tx_data = 8'h23;
            S_SPACE:         tx_data = 8'h20;
            S_CR:            tx_data = 8'h0D;
            S_LF:            tx_data = 8'h0A;
            S_ADDR, S_DIGIT: tx_data = hex_char(sh_q[SW-1 -: 4]);
            default:         tx_data = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        left_d     = left_q;
        line_d     = line_q;
        nib_d      = nib_q;
        wait_d     = wait_q;
        sh_d       = sh_q;
        abort_d    = abort_q | (abort & busy_w);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    left_d  = {1'b0, span} + (ADDR_W + 1)'(1);
                    line_d  = '0;
                    abort_d = 1'b0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (abort_now) begin
                        state_d = S_CR;
                    end else begin
                        // Address digits share the word shift register, left-aligned.
                        sh_d                = '0;
                        sh_d[SW-1 -: AW4]   = AW4'(addr_q);
                        nib_d               = '0;
                        state_d             = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (accept) begin
                    if (abort_now) begin
                        state_d = S_CR;
                    end else if (nib_q == 6'(AD - 1)) begin
                        state_d = S_SEP;
                    end else begin
                        sh_d  = sh_q << 4;
                        nib_d = nib_q + 6'd1;
                    end
                end
            end
            S_SEP: begin
                if (accept) begin
                    if (abort_now) begin
                        state_d = S_CR;
                    end else begin
                        mem_addr_d = addr_q;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (abort_now) begin
                    state_d = S_CR;
                end else begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_now) begin
                    state_d = S_CR;
                end else if (wait_q == 3'(RD_LAT - 1)) begin
                    sh_d                 = '0;
                    sh_d[SW-1 -: DATA_W] = mem_data;
                    nib_d                = '0;
                    addr_d               = addr_q + 1'b1;
                    left_d               = left_q - 1'b1;
                    line_d               = line_q + 8'd1;
                    state_d              = S_DIGIT;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_DIGIT: begin
                if (accept) begin
                    if (abort_now || left_q == '0 || line_q == 8'(WORDS_PER_LINE)) begin
                        if (abort_now || nib_q == 6'(ND - 1)) begin
                            state_d = S_CR;
                        end else begin
                            sh_d  = sh_q << 4;
                            nib_d = nib_q + 6'd1;
                        end
                    end else if (nib_q == 6'(ND - 1)) begin
                        state_d = S_SPACE;
                    end else begin
                        sh_d  = sh_q << 4;
                        nib_d = nib_q + 6'd1;
                    end
                end
            end
            S_SPACE: begin
                if (accept) begin
                    if (abort_now) begin
                        state_d = S_CR;
                    end else begin
                        mem_addr_d = addr_q;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_CR: begin
                if (accept) state_d = S_LF;
            end
            S_LF: begin
                if (accept) begin
                    line_d  = '0;
                    state_d = (abort_now || left_q == '0) ? S_FIN : S_HDR;
                end
            end
            S_FIN: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            left_q     <= '0;
            line_q     <= '0;
            nib_q      <= '0;
            wait_q     <= '0;
            sh_q       <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            left_q     <= left_d;
            line_q     <= line_d;
            nib_q      <= nib_d;
            wait_q     <= wait_d;
            sh_q       <= sh_d;
            abort_q    <= abort_d;
        end
    end

endmodule
